// File: rtl/ram_burst_ctrl.sv
// Single-port behavioural system RAM with independent read/write latencies,
// per-byte write enables, address-range checking and a sequential burst mode
// in which back-to-back consecutive-word accesses pay a reduced latency.

package ram_burst_ctrl_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned RD_LAT    = 3,
  parameter int unsigned WR_LAT    = 3,
  parameter int unsigned BURST_LAT = 1,
  parameter logic [31:0] BAD       = 32'hBAD1BAD1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ramREN,
  input  logic                  ramWEN,
  input  logic [ADDR_W-1:0]     ramaddr,
  input  logic [DATA_W-1:0]     ramstore,
  input  logic [DATA_W/8-1:0]   rambyteen,
  input  logic                  ramburst,
  output logic [DATA_W-1:0]     ramload,
  output ramstate_t             ramstate
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned BSHIFT  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W   = ADDR_W - BSHIFT;
  localparam int unsigned MIDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned REPS    = (DATA_W + 31) / 32;

  // BAD pattern replicated then truncated to the data width
  localparam logic [REPS*32-1:0] BAD_REP = {REPS{BAD}};
  localparam logic [DATA_W-1:0]  BAD_W   = BAD_REP[DATA_W-1:0];

  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);
  localparam logic [3:0] BU_L = 4'(BURST_LAT);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        mode;
  logic [1:0]        prev_mode;
  logic [ADDR_W-1:0] prev_addr;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  prev_idx;
  logic [MIDX_W-1:0] midx;
  logic              prev_active;
  logic              prev_access;
  logic              prev_burst;
  logic              req;
  logic              new_req;
  logic              bad_idx;
  logic              hit;
  logic [3:0]        cnt;
  logic [3:0]        cnt_eff;
  logic [3:0]        cnt_next;
  logic [3:0]        lat;
  logic [3:0]        lat_q;
  ramstate_t         state;

  assign idx      = ramaddr[ADDR_W-1:BSHIFT];
  assign prev_idx = prev_addr[ADDR_W-1:BSHIFT];
  assign midx     = idx[MIDX_W-1:0];

  // Classify the current cycle: new vs. continued request, burst hit, latency and status
  always_comb begin
    mode     = {ramREN, ramWEN};
    req      = ramREN | ramWEN;
    bad_idx  = 32'(idx) >= DEPTH;
    new_req  = !prev_active || (mode != prev_mode) || (ramaddr != prev_addr);
    // 32-bit compare so the top index never chains into index 0
    hit      = prev_access && prev_burst && ramburst && (mode == prev_mode) &&
               (32'(idx) == 32'(prev_idx) + 32'd1);
    if (new_req) begin
      if (hit)         lat = BU_L;
      else if (ramREN) lat = RD_L;
      else             lat = WR_L;
    end else begin
      lat = lat_q;
    end
    // A new request counts from zero in its first cycle
    cnt_eff  = new_req ? 4'd0 : cnt;
    cnt_next = (cnt_eff >= lat) ? lat : cnt_eff + 4'd1;

    if (!nRST)                                state = FREE;
    else if ((ramREN && ramWEN) || (req && bad_idx)) state = ERROR;
    else if (!req)                            state = FREE;
    else if (cnt_eff >= lat)                  state = ACCESS;
    else                                      state = BUSY;

    ramstate = state;
    ramload  = ((state == ACCESS) && ramREN) ? mem[midx] : BAD_W;
  end

  // Latch request identity, latency counter and burst-chain history for the next cycle
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      prev_mode   <= '0;
      prev_addr   <= '0;
      prev_active <= 1'b0;
      prev_access <= 1'b0;
      prev_burst  <= 1'b0;
      lat_q       <= '0;
      cnt         <= '0;
    end else begin
      prev_mode   <= mode;
      prev_addr   <= ramaddr;
      prev_burst  <= ramburst;
      prev_active <= (state == BUSY) || (state == ACCESS);
      prev_access <= (state == ACCESS);
      lat_q       <= lat;
      cnt         <= ((state == BUSY) || (state == ACCESS)) ? cnt_next : '0;
    end
  end

  // Commit enabled bytes on every ACCESS write cycle; contents survive reset
  always_ff @(posedge CLK) begin
    if ((state == ACCESS) && ramWEN) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (rambyteen[b]) mem[midx][8*b +: 8] <= ramstore[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: the driver computes per-cycle expected
// status/data from a transaction-level model and queues it; a negedge monitor
// pops and compares against the DUT outputs.

module tb_ram_burst_ctrl;
  import ram_burst_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 1024;
  localparam int RL  = 3;
  localparam int WL  = 4;
  localparam int BL  = 1;
  localparam logic [31:0] BADV = 32'hBAD1BAD1;
  localparam int WIN = 128;

  logic            CLK;
  logic            nRST;
  logic            ramREN;
  logic            ramWEN;
  logic [AW-1:0]   ramaddr;
  logic [DW-1:0]   ramstore;
  logic [DW/8-1:0] rambyteen;
  logic            ramburst;
  logic [DW-1:0]   ramload;
  ramstate_t       ramstate;

  ram_burst_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
    .RD_LAT(RL), .WR_LAT(WL), .BURST_LAT(BL), .BAD(BADV)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .rambyteen(rambyteen),
    .ramburst(ramburst), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    ramstate_t   st;
    logic [31:0] ld;
    int          id;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   seq   = 0;

  // reference model: word memory plus what the previous transaction looked like
  logic [31:0] mdl_mem [DEP];
  bit          last_contig = 0;
  bit          last_acc    = 0;
  bit          last_burst  = 0;
  logic [1:0]  last_mode   = 2'b00;
  logic [15:0] last_addr   = '0;
  int          last_idx    = -5;

  task automatic push(input ramstate_t st, input logic [31:0] ld);
    exp_t e;
    e.st = st; e.ld = ld; e.id = seq;
    expq.push_back(e);
    seq++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nRST = 1'b1; ramREN = 1'b0; ramWEN = 1'b0;
      ramburst = bit'($urandom_range(0, 1));
      push(FREE, BADV);
      tick();
    end
    last_contig = 0; last_acc = 0;
  endtask

  task automatic rst_cycle();
    nRST = 1'b0;
    push(FREE, BADV);
    tick();
    nRST = 1'b1;
    last_contig = 0; last_acc = 0;
  endtask

  // hold one request for 'hold' cycles; hold<=0 means "until first ACCESS"
  task automatic req(input bit ren, input bit wen, input logic [15:0] addr,
                     input logic [31:0] data, input logic [3:0] be,
                     input bit burst, input int hold);
    int idx, L, n;
    bit err, hit;
    ramstate_t st;
    logic [31:0] ld;
    if (last_contig && last_mode == {ren, wen} && last_addr == addr) idle(1);
    idx = int'(addr >> 2);
    err = (ren && wen) || (idx >= DEP);
    hit = last_contig && last_acc && last_burst && burst &&
          (last_mode == {ren, wen}) && (idx == last_idx + 1);
    L   = hit ? BL : (ren ? RL : WL);
    n   = (hold > 0) ? hold : (err ? 2 : L + 1);
    nRST = 1'b1; ramREN = ren; ramWEN = wen; ramaddr = addr;
    ramstore = data; rambyteen = be; ramburst = burst;
    for (int i = 0; i < n; i++) begin
      if (err) begin
        st = ERROR; ld = BADV;
      end else if (i < L) begin
        st = BUSY; ld = BADV;
      end else begin
        st = ACCESS; ld = ren ? mdl_mem[idx] : BADV;
      end
      push(st, ld);
      if (st == ACCESS && wen)
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
      tick();
    end
    last_contig = 1; last_acc = !err && (n > L); last_burst = burst;
    last_mode = {ren, wen}; last_addr = addr; last_idx = idx;
  endtask

  // monitor: compare every presented cycle against the queued expectation
  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      tests++;
      if (ramstate !== e.st) begin
        fails++;
        $display("FAIL ramstate #%0d: got %0d want %0d", e.id, int'(ramstate), int'(e.st));
      end
      tests++;
      if (ramload !== e.ld) begin
        fails++;
        $display("FAIL ramload #%0d: got %h want %h", e.id, ramload, e.ld);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    bit          r;
    int          c;
    nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0;
    ramstore = '0; rambyteen = '0; ramburst = 1'b0;
    @(posedge CLK); #1;

    // reset state
    rst_cycle();
    rst_cycle();

    // seed the working window and the top two words
    for (int i = 0; i < WIN; i++)
      req(0, 1, 16'(i * 4), (i == 4) ? 32'h11223344 : $urandom, 4'hF, 0, 0);
    req(0, 1, 16'h0FF8, $urandom, 4'hF, 0, 0);
    req(0, 1, 16'h0FFC, $urandom, 4'hF, 0, 0);
    idle(1);

    // plain read held five cycles
    req(1, 0, 16'h0000, '0, 4'h0, 0, 5);
    idle(1);

    // byte-enabled write then read-after-write
    req(0, 1, 16'h0010, 32'hDEADBEEF, 4'b0101, 0, 0);
    req(1, 0, 16'h0010, '0, 4'h0, 0, 0);
    idle(1);

    // burst read chain, then the same without burst
    req(1, 0, 16'h0100, '0, 4'h0, 1, 0);
    req(1, 0, 16'h0104, '0, 4'h0, 1, 0);
    req(1, 0, 16'h0108, '0, 4'h0, 1, 0);
    idle(1);
    req(1, 0, 16'h0100, '0, 4'h0, 0, 0);
    req(1, 0, 16'h0104, '0, 4'h0, 0, 0);
    req(1, 0, 16'h0108, '0, 4'h0, 0, 0);
    idle(1);

    // burst write chain
    req(0, 1, 16'h0040, 32'hA5A5_0001, 4'hF, 1, 0);
    req(0, 1, 16'h0044, 32'hA5A5_0002, 4'hF, 1, 0);
    req(1, 0, 16'h0044, '0, 4'h0, 0, 0);
    idle(1);

    // error cases and recovery
    req(1, 1, 16'h0010, 32'h0BAD_0BAD, 4'hF, 0, 3);
    req(1, 0, 16'h1000, '0, 4'h0, 0, 3);
    req(0, 1, 16'hFFFC, 32'h1234_5678, 4'hF, 0, 3);
    idle(2);
    req(1, 0, 16'h0010, '0, 4'h0, 0, 0);

    // address change mid-BUSY restarts the count
    req(1, 0, 16'h0020, '0, 4'h0, 0, 2);
    req(1, 0, 16'h0024, '0, 4'h0, 0, 5);
    idle(1);

    // reset mid-write: no commit, restart with full latency
    req(0, 1, 16'h0030, 32'hCAFE_F00D, 4'hF, 0, 2);
    rst_cycle();
    idle(1);
    req(1, 0, 16'h0030, '0, 4'h0, 0, 0);
    req(0, 1, 16'h0030, 32'hCAFE_F00D, 4'hF, 0, 2);
    rst_cycle();
    req(0, 1, 16'h0030, 32'hCAFE_F00D, 4'hF, 0, 0);
    req(1, 0, 16'h0030, '0, 4'h0, 0, 0);
    idle(1);

    // burst up to the last word, then one past the end
    req(1, 0, 16'h0FF8, '0, 4'h0, 1, 0);
    req(1, 0, 16'h0FFC, '0, 4'h0, 1, 0);
    req(1, 0, 16'h1000, '0, 4'h0, 1, 3);
    idle(1);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      c = $urandom_range(0, 99);
      if (c < 8) begin
        idle($urandom_range(1, 2));
      end else if (c < 14) begin
        req(1, 1, 16'($urandom_range(0, WIN - 1) * 4), $urandom, 4'($urandom), 0,
            $urandom_range(1, 3));
      end else if (c < 20) begin
        r = bit'($urandom_range(0, 1));
        req(r, !r, 16'($urandom_range(32'h1000, 32'hFFFF)), $urandom, 4'($urandom),
            bit'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else if (c < 24) begin
        rst_cycle();
      end else begin
        r = bit'($urandom_range(0, 1));
        if (last_contig && (last_idx + 1 < WIN) && last_idx >= 0 && ($urandom_range(0, 1) == 1))
          a = 16'((last_idx + 1) * 4);
        else
          a = 16'($urandom_range(0, WIN - 1) * 4);
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
        req(r, !r, a, $urandom, 4'($urandom), $urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
      end
    end
    idle(2);

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Parametrised successor to the single-port variable-latency system RAM model. Sits behind the memory arbiter on the cpu_ram interface signals.
- Adds independent read and write latencies, per-byte write enables, and address-range checking.
- Adds a sequential burst mode: back-to-back consecutive-word accesses pay a reduced latency.
- Memory is an internal behavioural word array.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 16, byte-address width.
- DEPTH, 16384, number of words; must satisfy DEPTH*(DATA_W/8) <= 2^ADDR_W.
- RD_LAT, 3, read latency in cycles (1..15).
- WR_LAT, 3, write latency in cycles (1..15).
- BURST_LAT, 1, latency of a burst-continuation access (1..15; must be <= RD_LAT and <= WR_LAT).
- BAD, 32'hBAD1BAD1, value driven on ramload when no read data is valid; replicated/truncated to DATA_W.

Ports:
- CLK  in  1  clock; rising edge.
- nRST  in  1  reset.
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramaddr  in  ADDR_W  byte address. Word index = ramaddr >> log2(DATA_W/8); low bits are ignored.
- ramstore  in  DATA_W  write data.
- rambyteen  in  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
- ramburst  in  1  burst hint; requests reduced latency for the next consecutive word.
- ramload  out  DATA_W  read data.
- ramstate  out  2  ramstate_t status: FREE, BUSY, ACCESS or ERROR.

Behaviour:
- Reset: one clock, synchronous, active-low (nRST=0 sampled at posedge CLK resets).
  - Reset clears the latency counter, latched address/mode, and burst-chain flag.
  - Memory contents are preserved.
  - While nRST=0: ramstate=FREE, ramload=BAD, no write commits.
- Request: mode = {ramREN, ramWEN}.
  - A new request starts in any cycle where mode or ramaddr differs from the value latched at the previous edge, or the previous cycle was idle.
- ramstate (combinational), in priority order:
  - ERROR: REN and WEN both high, or word index >= DEPTH with a request active.
  - FREE: no request.
  - ACCESS: request has been held with unchanged address/mode for L cycles, where L = RD_LAT for reads, WR_LAT for writes, BURST_LAT for burst hits.
  - BUSY: otherwise.
  - Timing: a request first presented in cycle N shows BUSY in cycles N..N+L-1 and ACCESS in cycle N+L and every following cycle while held.
- Counter: restarts on every new request, saturates at L, and is held at 0 while FREE or ERROR.
- Burst hit (evaluated in the first cycle of a new request):
  - Conditions: the previous cycle was ACCESS; ramburst was high in that cycle and is high now; mode is unchanged; new word index = previous index + 1.
  - On a hit, L = BURST_LAT. On a miss, L is the full latency.
  - Any BUSY-to-idle, ERROR, or mode change breaks the chain.
  - Address wrap is not allowed: an index past DEPTH-1 gives ERROR.
- Read: ramload = mem[index] when ramstate=ACCESS and REN; otherwise BAD.
- Write: at each posedge with ramstate=ACCESS and WEN, bytes with rambyteen=1 are written from ramstore.
  - Holding the same request rewrites identical data; this is harmless.
  - rambyteen=0 produces ACCESS with no change to memory.
- Read-after-write to the same address is a new request (mode change) and returns the committed data after RD_LAT.
- Reset mid-request: the request is aborted with no write commit. If it is still held after release, it restarts with full latency.

Test Plan:
- Read at 0x0000 holding REN for 5 cycles (RD_LAT=3) -> ramstate BUSY,BUSY,BUSY,ACCESS,ACCESS; ramload=BAD for 3 cycles, then mem[0].
- Write 0xDEADBEEF to 0x0010 with rambyteen=4'b0101 over old 0x11223344 (WR_LAT=3), then read 0x0010 -> BUSY x3, ACCESS; read returns 0x11AD33EF.
- Burst read 0x0100, 0x0104, 0x0108 with ramburst=1, each address advanced on ACCESS -> first word after 3 BUSY cycles, next two after 1 BUSY each. Repeating with ramburst=0 -> 3 BUSY cycles each.
- REN=WEN=1 -> ERROR, ramload=BAD, no write. Address 0x10000 equivalent (index=DEPTH) with REN -> ERROR. Drop both -> FREE.
- Address changed mid-BUSY (0x0020 -> 0x0024 after 2 cycles) -> counter restarts; ACCESS 3 cycles after the change.
- nRST=0 for 1 cycle during a write's second BUSY cycle -> FREE during reset, memory unchanged; after release ACCESS comes 3 cycles later, then data is committed.
